// File: rtl/cache_line_fill_pkg.sv
// Shared SDRAM cache definitions: default line geometry and the line-fill
// state encoding used by the cache controller and the line-fill engine.
package cache_line_fill_pkg;

  localparam int LINE_WORDS_DEF      = 4;
  localparam int LINE_WORDS_LOG2_DEF = $clog2(LINE_WORDS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/cache_line_fill.sv
// Cache line fill engine: requests one SDRAM burst per missed line and writes
// the returned beats into the cache data RAM, flagging the critical word.
// Optional build macro CACHE_FILL_CWF_EN selects critical-word-first bursts;
// without it every burst starts at word 0 of the line.
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int RAM_AW     = 10,
  parameter int SD_AW      = 24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fill_req,
  input  logic [RAM_AW-$clog2(LINE_WORDS)-1:0] fill_idx,
  input  logic [SD_AW-1:0]                     fill_adr,
  output logic                                 fill_ack,
  output logic                                 fill_cw_vld,
  output logic [15:0]                          fill_cw_dat,
  output logic                                 fill_done,
  output logic                                 busy,
  output logic                                 sd_req,
  output logic [SD_AW-1:0]                     sd_adr,
  input  logic                                 sd_ack,
  input  logic                                 sd_vld,
  input  logic [15:0]                          sd_dat,
  output logic                                 ram_wren,
  output logic [1:0]                           ram_byteena,
  output logic [RAM_AW-1:0]                    ram_address,
  output logic [15:0]                          ram_data
);

  localparam int OFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W = RAM_AW - OFS_W;

  fill_state_t      state;
  logic [IDX_W-1:0] line_idx;
  logic [OFS_W-1:0] word_ptr;
  logic [OFS_W-1:0] beat_cnt;
  logic [SD_AW-1:0] start_adr;
  logic [OFS_W-1:0] start_ofs;
  logic             beat;
  logic             last_beat;

`ifdef CACHE_FILL_CWF_EN
  assign start_adr = fill_adr;
  assign start_ofs = fill_adr[OFS_W-1:0];
`else
  assign start_adr = fill_adr & ~SD_AW'(LINE_WORDS - 1);
  assign start_ofs = '0;
`endif

  assign beat      = ((state == ST_BURST) && sd_vld) ||
                     ((state == ST_REQ) && sd_ack && sd_vld);
  assign last_beat = (beat_cnt == OFS_W'(LINE_WORDS - 1));

  // Fill sequencing plus registered RAM write, critical-word and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      line_idx    <= '0;
      word_ptr    <= '0;
      beat_cnt    <= '0;
      fill_ack    <= 1'b0;
      fill_cw_vld <= 1'b0;
      fill_cw_dat <= '0;
      fill_done   <= 1'b0;
      busy        <= 1'b0;
      sd_req      <= 1'b0;
      sd_adr      <= '0;
      ram_wren    <= 1'b0;
      ram_byteena <= 2'b00;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      fill_ack    <= 1'b0;
      fill_cw_vld <= 1'b0;
      fill_done   <= 1'b0;
      ram_wren    <= 1'b0;
      ram_byteena <= 2'b00;

      case (state)
        ST_IDLE: begin
          if (fill_req) begin
            state    <= ST_REQ;
            busy     <= 1'b1;
            fill_ack <= 1'b1;
            sd_req   <= 1'b1;
            sd_adr   <= start_adr;
            line_idx <= fill_idx;
            word_ptr <= start_ofs;
            beat_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (sd_ack) begin
            state  <= ST_BURST;
            sd_req <= 1'b0;
          end
        end
        ST_BURST: begin
          if (beat && last_beat) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          sd_req <= 1'b0;
        end
      endcase

      if (beat) begin
        ram_wren    <= 1'b1;
        ram_byteena <= 2'b11;
        ram_address <= {line_idx, word_ptr};
        ram_data    <= sd_dat;
        word_ptr    <= word_ptr + 1'b1;
        beat_cnt    <= beat_cnt + 1'b1;
        if (beat_cnt == '0) begin
          fill_cw_vld <= 1'b1;
          fill_cw_dat <= sd_dat;
        end
        if (last_beat) begin
          fill_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: directed fills for the documented
// scenarios plus randomized fills, all checked against a transaction model.
module tb_cache_line_fill;

  localparam int LW     = 4;
  localparam int RAM_AW = 10;
  localparam int SD_AW  = 24;
  localparam int IDX_W  = RAM_AW - 2;

  logic              clk;
  logic              rst;
  logic              fill_req;
  logic [IDX_W-1:0]  fill_idx;
  logic [SD_AW-1:0]  fill_adr;
  logic              fill_ack;
  logic              fill_cw_vld;
  logic [15:0]       fill_cw_dat;
  logic              fill_done;
  logic              busy;
  logic              sd_req;
  logic [SD_AW-1:0]  sd_adr;
  logic              sd_ack;
  logic              sd_vld;
  logic [15:0]       sd_dat;
  logic              ram_wren;
  logic [1:0]        ram_byteena;
  logic [RAM_AW-1:0] ram_address;
  logic [15:0]       ram_data;

  int numChecks = 0;
  int numPassed = 0;

  cache_line_fill #(.LINE_WORDS(LW), .RAM_AW(RAM_AW), .SD_AW(SD_AW)) dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_idx(fill_idx), .fill_adr(fill_adr),
    .fill_ack(fill_ack), .fill_cw_vld(fill_cw_vld), .fill_cw_dat(fill_cw_dat),
    .fill_done(fill_done), .busy(busy),
    .sd_req(sd_req), .sd_adr(sd_adr), .sd_ack(sd_ack),
    .sd_vld(sd_vld), .sd_dat(sd_dat),
    .ram_wren(ram_wren), .ram_byteena(ram_byteena),
    .ram_address(ram_address), .ram_data(ram_data)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual === expected) numPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Advance past the next rising edge so registered outputs have settled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete line fill. The model works at transaction level: expected
  // burst address and RAM addresses follow from the line index, the missed
  // address and the beat number; beats are the first LW sd_vld cycles from the
  // sd_ack cycle onward. beatMask bit n drives sd_vld n cycles after sd_ack.
  task automatic applyStimulus(input int idx, input int adr, input int ackDelay,
                               input logic [31:0] beatMask, input bit holdReq,
                               input int rstAfter);
    int expSdAdr;
    int ofs;
    int beats;
    int tail;
    int expAddr;
    logic [15:0] cwData;
    bit cwf;
`ifdef CACHE_FILL_CWF_EN
    cwf = 1'b1;
`else
    cwf = 1'b0;
`endif
    expSdAdr = cwf ? adr : (adr / LW) * LW;
    ofs      = cwf ? (adr % LW) : 0;
    beats    = 0;
    tail     = -1;
    cwData   = '0;

    fill_idx = IDX_W'(idx);
    fill_adr = SD_AW'(adr);
    fill_req = 1'b1;
    stepCycle();
    checkOutput("fill_ack", fill_ack, 1);
    checkOutput("busy_start", busy, 1);
    checkOutput("sd_req_start", sd_req, 1);
    checkOutput("sd_adr", sd_adr, expSdAdr);
    if (holdReq) begin
      fill_idx = ~IDX_W'(idx);
      fill_adr = SD_AW'($urandom);
    end else begin
      fill_req = 1'b0;
    end

    for (int c = 0; c < 80; c++) begin
      int rel;
      int acc;
      rel = c - ackDelay;
      acc = -1;
      if (rstAfter > 0 && beats == rstAfter) begin
        fill_req = 1'b0;
        sd_ack   = 1'b0;
        sd_vld   = 1'b1;
        sd_dat   = 16'($urandom);
        rst      = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("rst_wren", ram_wren, 0);
        checkOutput("rst_byteena", ram_byteena, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sd_req", sd_req, 0);
        checkOutput("rst_sd_adr", sd_adr, 0);
        checkOutput("rst_cw_dat", fill_cw_dat, 0);
        checkOutput("rst_ram_addr", ram_address, 0);
        checkOutput("rst_ram_data", ram_data, 0);
        checkOutput("rst_done", fill_done, 0);
        for (int k = 0; k < 3; k++) begin
          stepCycle();
          checkOutput("post_rst_wren", ram_wren, 0);
          checkOutput("post_rst_busy", busy, 0);
        end
        sd_vld = 1'b0;
        return;
      end
      sd_ack = (rel == 0);
      sd_vld = (rel >= 0 && rel < 32) ? beatMask[rel] : 1'b0;
      sd_dat = 16'($urandom);
      if (sd_vld && beats < LW) acc = beats;
      stepCycle();
      if (tail >= 0) tail++;

      checkOutput("ram_wren", ram_wren, (acc >= 0) ? 1 : 0);
      checkOutput("fill_ack_busy", fill_ack, 0);
      checkOutput("sd_req", sd_req, (rel < 0) ? 1 : 0);
      if (rel < 0) checkOutput("sd_adr_hold", sd_adr, expSdAdr);
      if (acc >= 0) begin
        expAddr = idx * LW + ((ofs + acc) % LW);
        checkOutput("ram_address", ram_address, expAddr);
        checkOutput("ram_data", ram_data, sd_dat);
        checkOutput("ram_byteena", ram_byteena, 3);
        checkOutput("fill_cw_vld", fill_cw_vld, (acc == 0) ? 1 : 0);
        checkOutput("fill_done", fill_done, (acc == LW - 1) ? 1 : 0);
        if (acc == 0) begin
          cwData = sd_dat;
          checkOutput("fill_cw_dat", fill_cw_dat, cwData);
        end
        beats++;
        if (acc == LW - 1) tail = 0;
      end else begin
        checkOutput("fill_done_idle", fill_done, 0);
      end
      checkOutput("busy", busy, (tail < 1) ? 1 : 0);
      if (tail == 0 && holdReq) fill_req = 1'b0;
      if (tail >= 1) checkOutput("cw_dat_hold", fill_cw_dat, cwData);
      if (tail == 2) begin
        sd_vld = 1'b0;
        sd_ack = 1'b0;
        return;
      end
    end
    checkOutput("fill_timeout", 0, 1);
    fill_req = 1'b0;
    sd_vld   = 1'b0;
    sd_ack   = 1'b0;
  endtask

  // Reset checks, directed scenarios, then randomized fills.
  initial begin
    rst      = 1'b1;
    fill_req = 1'b0;
    fill_idx = '0;
    fill_adr = '0;
    sd_ack   = 1'b0;
    sd_vld   = 1'b0;
    sd_dat   = '0;
    stepCycle();
    stepCycle();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sd_req", sd_req, 0);
    checkOutput("reset_wren", ram_wren, 0);
    checkOutput("reset_byteena", ram_byteena, 0);
    checkOutput("reset_cw_dat", fill_cw_dat, 0);
    rst = 1'b0;
    stepCycle();
    checkOutput("idle_busy", busy, 0);

    $display("[TB] directed fill: idx 0x05, adr 0x000102");
    applyStimulus(5, 'h102, 3, 32'h0000_000F, 1'b0, 0);
    $display("[TB] gapped beats with a surplus fifth beat");
    applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 32'hFFFFFF)),
                  1, 32'h0000_00E5, 1'b0, 0);
    $display("[TB] request held while busy");
    applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 32'hFFFFFF)),
                  2, 32'h0000_001E, 1'b1, 0);
    $display("[TB] reset after second beat");
    applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 32'hFFFFFF)),
                  0, 32'h0000_00FF, 1'b0, 2);
    $display("[TB] fill after reset");
    applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 32'hFFFFFF)),
                  1, 32'h0000_000F, 1'b0, 0);

    $display("[TB] randomized fills");
    for (int n = 0; n < 25; n++) begin
      logic [31:0] mask;
      mask = $urandom | 32'hF000_0000;
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 32'hFFFFFF)),
                    int'($urandom_range(0, 5)), mask, 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 16-bit words per cache line and SDRAM burst length (power of two, 2..8).
REQ-002 SHALL have parameter RAM_AW, default 10, meaning cache data RAM word-address width.
REQ-003 SHALL have parameter SD_AW, default 24, meaning SDRAM word-address width.
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- fill_req  in  1  line fill request, held by requester until fill_ack
- fill_idx  in  RAM_AW-log2(LINE_WORDS)  destination line index in RAM
- fill_adr  in  SD_AW  SDRAM word address of missed word
- fill_ack  out  1  one-cycle pulse, request latched
- fill_cw_vld  out  1  one-cycle pulse, critical word available
- fill_cw_dat  out  16  critical word data
- fill_done  out  1  one-cycle pulse, whole line written
- busy  out  1  fill in progress
- sd_req  out  1  SDRAM burst read request
- sd_adr  out  SD_AW  SDRAM burst start address
- sd_ack  in  1  SDRAM accepted request
- sd_vld  in  1  burst data beat valid
- sd_dat  in  16  burst data
- ram_wren  out  1  RAM write enable
- ram_byteena  out  2  RAM byte enables
- ram_address  out  RAM_AW  RAM write address
- ram_data  out  16  RAM write data

Function
REQ-005 SHALL implement states IDLE, REQ, BURST, DONE; busy=1 in every state except IDLE.
REQ-006 IDLE with fill_req=1 SHALL latch fill_idx and fill_adr, move to REQ next cycle, and drive fill_ack=1 for that single cycle.
REQ-007 fill_req during non-IDLE states SHALL be ignored.
REQ-008 REQ SHALL hold sd_req=1 and sd_adr constant until sd_ack=1 is sampled; it then moves to BURST and drops sd_req the following cycle.
REQ-009 A beat SHALL be accepted when sd_vld=1 in BURST, or in REQ coincident with sd_ack=1; sd_vld in IDLE or DONE SHALL be ignored.
REQ-010 Each accepted beat SHALL produce, one cycle later, ram_wren=1, ram_byteena=2'b11, ram_data=sd_dat, ram_address={latched idx, word pointer}.
REQ-011 The word pointer SHALL start at the start offset (REQ-017), increment by one per beat, and wrap modulo LINE_WORDS within the line.
REQ-012 The first beat SHALL also assert fill_cw_vld with fill_cw_dat=sd_dat, in the same cycle as its RAM write.
REQ-013 After LINE_WORDS beats, the SM SHALL enter DONE for one cycle, pulse fill_done (same cycle as last RAM write), then return to IDLE; further sd_vld beats SHALL be ignored.
REQ-014 Non-consecutive sd_vld beats SHALL be accepted; no timeout.
REQ-015 fill_cw_dat SHALL hold its value between fills.

Reset
REQ-016 rst=1 SHALL, at any state including mid-burst, force IDLE and zero all outputs (ram_byteena=0); no RAM write SHALL follow the reset edge.

Configuration
REQ-017 Macro CACHE_FILL_CWF_EN: defined -> sd_adr=fill_adr and start offset = fill_adr[log2(LINE_WORDS)-1:0] (critical word first, wrapping burst); undefined -> sd_adr=fill_adr with low log2(LINE_WORDS) bits zeroed, start offset 0, fill_cw_vld still pulses on the first beat (word 0).

Structure
REQ-018 LINE_WORDS default, its log2 and the state encoding SHALL reside in the shared sdram cache package/include used by the cache controller.
REQ-019 No sub-module; the cache data RAM is instantiated by the parent and driven on one port.

Verification
REQ-020 CWF_EN, LINE_WORDS=4: fill_idx=0x05, fill_adr=0x000102, sd_ack after 3 cycles, beats A,B,C,D -> sd_adr=0x000102, writes at RAM 0x016,0x017,0x014,0x015, fill_cw_dat=A, fill_done with the 0x015 write.
REQ-021 CWF_EN undefined, same stimulus -> sd_adr=0x000100, writes at 0x014..0x017, fill_cw_dat=A.
REQ-022 sd_vld with gaps (beats at cycles 0,2,5,6) -> exactly 4 writes, fill_done one cycle after beat 4; a 5th sd_vld -> no write.
REQ-023 fill_req asserted while busy -> no fill_ack, no state change; ack issued after return to IDLE.
REQ-024 rst asserted after beat 2 -> no further ram_wren, all outputs 0, busy=0; next fill_req completes normally.
REQ-025 sd_vld coincident with sd_ack -> counted as beat 0, RAM write one cycle later.
